// File: rtl/irq_flag_ctrl.sv
// rtl/irq_flag_ctrl.sv - IF flag register, fixed-priority arbiter and CPU irq/ack handshake
// Build option IRQ_SYNC_EN: 2-flop synchronizer on src_req for sources from another clock domain.
module irq_flag_ctrl #(
    parameter int N_SRC = 5,
    parameter int VEC_W = 3,
    parameter logic [N_SRC-1:0] INITIAL_IF = '0
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [N_SRC-1:0] src_req,
    input  logic [N_SRC-1:0] ie,
    input  logic             if_wr,
    input  logic [N_SRC-1:0] if_wdata,
    output logic [N_SRC-1:0] if_q,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    input  logic             ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [VEC_W-1:0] vec_nx;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] s_prev;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] vec_sel;
    logic [N_SRC-1:0] if_nx;
    logic [VEC_W-1:0] win;
    logic             win_found;
    logic             pend_vec;
    logic             ack_clr;
    logic [1:0]       arm_cnt;
    logic             armed;

`ifdef IRQ_SYNC_EN
    localparam int ARM_EDGES = 3;
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_req;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    localparam int ARM_EDGES = 1;

    assign s = src_req;
`endif

    // Rises are ignored until s_prev holds a real sample, so a source already high at reset release is not an edge.
    assign armed = (arm_cnt == 2'(ARM_EDGES));
    assign rise  = armed ? (s & ~s_prev) : '0;
    assign pend  = if_q & ie;

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        vec_sel   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!win_found && pend[i]) begin
                win       = VEC_W'(i);
                win_found = 1'b1;
            end
            vec_sel[i] = (VEC_W'(i) == vec);
        end
        pend_vec = |(pend & vec_sel);
    end

    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        ack_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (pend != '0) begin
                    vec_nx   = win;
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                if (ack) begin
                    ack_clr  = 1'b1;
                    state_nx = DONE;
                end else if (!pend_vec) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                if (!ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Set beats ack-clear beats CPU write beats hold.
    always_comb begin
        if_nx = if_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (rise[i]) begin
                if_nx[i] = 1'b1;
            end else if (ack_clr && vec_sel[i]) begin
                if_nx[i] = 1'b0;
            end else if (if_wr) begin
                if_nx[i] = if_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state   <= IDLE;
            vec     <= '0;
            irq     <= 1'b0;
            if_q    <= INITIAL_IF;
            s_prev  <= '0;
            arm_cnt <= '0;
        end else begin
            state  <= state_nx;
            vec    <= vec_nx;
            irq    <= (state_nx == OFFER);
            if_q   <= if_nx;
            s_prev <= s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// tb/tb_irq_flag_ctrl.sv - self-checking bench for irq_flag_ctrl: directed cases plus randomized run against a model
module tb_irq_flag_ctrl;
    localparam int N  = 5;
    localparam int VW = 3;
    localparam logic [N-1:0] INIT = 5'b00001;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [N-1:0]  src_req = '0;
    logic [N-1:0]  ie = '0;
    logic          if_wr = 1'b0;
    logic [N-1:0]  if_wdata = '0;
    logic [N-1:0]  if_q;
    logic          irq;
    logic [VW-1:0] vec;
    logic          ack = 1'b0;

    irq_flag_ctrl #(.N_SRC(N), .VEC_W(VW), .INITIAL_IF(INIT)) dut (
        .clk(clk), .nreset(nreset), .src_req(src_req), .ie(ie), .if_wr(if_wr),
        .if_wdata(if_wdata), .if_q(if_q), .irq(irq), .vec(vec), .ack(ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags as whole vectors, handshake as a phase number (0 idle, 1 offered, 2 acked).
    logic [N-1:0]  m_if = INIT;
    logic [N-1:0]  m_sprev = '0;
    logic [N-1:0]  m_h1 = '0;
    logic [N-1:0]  m_h2 = '0;
    logic [VW-1:0] m_vec = '0;
    int            m_phase = 0;
    int            m_edges = 0;

    function automatic logic [VW-1:0] lowest(input logic [N-1:0] p);
        for (int i = 0; i < N; i++) if (p[i]) return VW'(i);
        return '0;
    endfunction

    task automatic model_step();
        logic [N-1:0] s_now, rise, clr, pend;
        s_now = (LAT == 2) ? m_h2 : src_req;
        m_edges++;
        rise = (m_edges > LAT + 1) ? (s_now & ~m_sprev) : '0;
        clr  = (m_phase == 1 && ack) ? (N'(1) << m_vec) : '0;
        pend = m_if & ie;
        if (m_phase == 0) begin
            if (pend != 0) begin
                m_vec = lowest(pend);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
            else if (!pend[m_vec]) m_phase = 0;
        end else begin
            if (!ack) m_phase = 0;
        end
        m_if = rise | (~clr & (if_wr ? if_wdata : m_if));
        m_sprev = s_now;
        m_h2 = m_h1;
        m_h1 = src_req;
    endtask

    initial forever begin
        @(posedge clk or posedge nreset);
        if (nreset) begin
            m_if = INIT; m_sprev = '0; m_h1 = '0; m_h2 = '0;
            m_vec = '0; m_phase = 0; m_edges = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!nreset) begin
            chk("model_if_q", if_q, m_if);
            chk("model_irq", irq, (m_phase == 1));
            if (m_phase == 1) chk("model_vec", vec, m_vec);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_cycle();
        ack = 1'b1; tick(1);
        ack = 1'b0; tick(2);
    endtask

    initial begin
        #1 nreset = 1'b1;
        #1;
        chk("reset_if_q", if_q, INIT);
        chk("reset_irq", irq, 0);
        chk("reset_vec", vec, 0);
        src_req = 5'b01000;
        tick(2);
        nreset = 1'b0;
        tick(LAT + 3);
        chk("high_at_release_no_rise", if_q, INIT);
        src_req = '0;
        tick(LAT + 2);

        // single source
        if_wr = 1'b1; if_wdata = '0; ie = 5'b00100; tick(1);
        if_wr = 1'b0;
        src_req = 5'b00100;
        tick(1 + LAT);
        chk("single_if_q", if_q, 5'b00100);
        chk("single_irq_not_yet", irq, 0);
        src_req = '0;
        tick(1);
        chk("single_irq", irq, 1);
        chk("single_vec", vec, 2);
        tick(2);
        ack = 1'b1; tick(1);
        chk("single_ack_if_q", if_q, 0);
        chk("single_ack_irq", irq, 0);
        tick(1);
        chk("single_done_irq", irq, 0);
        ack = 1'b0; tick(2);

        // priority
        ie = 5'b11111; src_req = 5'b01010;
        tick(1 + LAT);
        chk("prio_if_q", if_q, 5'b01010);
        src_req = '0;
        tick(1);
        chk("prio_first_vec", vec, 1);
        ack = 1'b1; tick(1);
        chk("prio_after_ack_if_q", if_q, 5'b01000);
        ack = 1'b0; tick(1);
        chk("prio_gap_irq", irq, 0);
        tick(1);
        chk("prio_second_irq", irq, 1);
        chk("prio_second_vec", vec, 3);
        ack_cycle();

        // set beats write-clear
        ie = '0; src_req = 5'b00001;
        tick(LAT);
        if_wr = 1'b1; if_wdata = '0; tick(1);
        chk("set_beats_write", if_q, 5'b00001);
        if_wr = 1'b1; if_wdata = '0; src_req = '0; tick(1);
        if_wr = 1'b0; tick(LAT + 2);

        // set beats ack-clear, re-offered
        ie = 5'b11111; src_req = 5'b10000;
        tick(LAT + 2);
        chk("rack_vec", vec, 4);
        src_req = '0; tick(2);
        src_req = 5'b10000; tick(LAT);
        ack = 1'b1; tick(1);
        chk("rack_flag_kept", if_q[4], 1);
        chk("rack_irq_drop", irq, 0);
        ack = 1'b0; tick(2);
        chk("rack_reoffer_irq", irq, 1);
        chk("rack_reoffer_vec", vec, 4);
        src_req = '0;
        ack_cycle();

        // withdrawal by write
        src_req = 5'b10000; tick(LAT + 2);
        chk("wd_irq", irq, 1);
        src_req = '0;
        if_wr = 1'b1; if_wdata = '0; tick(1);
        if_wr = 1'b0;
        chk("wd_if_q", if_q, 0);
        chk("wd_irq_still", irq, 1);
        tick(1);
        chk("wd_irq_drop", irq, 0);
        tick(2);

        // reset mid-handshake
        ie = 5'b00011; src_req = 5'b00010; tick(LAT + 2);
        chk("mid_irq", irq, 1);
        chk("mid_vec", vec, 1);
        #2 nreset = 1'b1;
        #1;
        chk("mid_reset_irq", irq, 0);
        chk("mid_reset_if_q", if_q, INIT);
        #1 nreset = 1'b0;
        tick(1);
        chk("post_reset_irq", irq, 1);
        chk("post_reset_vec", vec, 0);
        chk("post_reset_if_q", if_q, INIT);
        src_req = '0;
        ack_cycle();

        // randomized run
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) src_req[b] = ~src_req[b];
            if ($urandom_range(0, 15) == 0) ie = N'($urandom);
            if_wr = ($urandom_range(0, 7) == 0);
            if_wdata = N'($urandom);
            if (irq && !ack && $urandom_range(0, 2) == 0) ack = 1'b1;
            else if (ack && !irq && $urandom_range(0, 1) == 0) ack = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                #2 nreset = 1'b1;
                #1;
                chk("rand_reset_irq", irq, 0);
                chk("rand_reset_if_q", if_q, INIT);
                ack = 1'b0;
                #1 nreset = 1'b0;
            end
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_flag_ctrl.md
# irq_flag_ctrl

Interrupt-flag controller for the CPU core. It edge-detects N interrupt source lines and latches each one into a set/reset flag bit, which together form the IF register. It arbitrates the pending, enabled flags by fixed priority and runs a request/acknowledge handshake with the CPU sequencer. On acknowledge it clears the serviced flag. It owns every set/reset decision on the IF bits, so no other logic drives those flags directly.

## Interface
- `N_SRC`, 5, number of interrupt sources; bit 0 has the highest priority.
- `VEC_W`, 3, width of the vector index; must satisfy 2^VEC_W >= N_SRC.
- `INITIAL_IF`, 0, value loaded into the IF flags on reset.

- `clk`  in  1  system clock; all state changes on the posedge.
- `nreset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `src_req`  in  N_SRC  level inputs from the sources; a rising edge requests an interrupt.
- `ie`  in  N_SRC  interrupt-enable mask (IE register).
- `if_wr`  in  1  CPU write strobe for IF.
- `if_wdata`  in  N_SRC  IF write data.
- `if_q`  out  N_SRC  current IF flags.
- `irq`  out  1  registered; high while a vector is offered to the CPU.
- `vec`  out  VEC_W  index of the offered interrupt; stable while `irq` is high.
- `ack`  in  1  CPU acknowledge; level signal, held until `irq` drops.

## Operation
- Edge detect:
  - Per bit, `rise = s & ~s_prev`, where `s` is the sampled `src_req`.
  - `s_prev` is updated every cycle.
- Flag update, per bit, each posedge. Priority high to low:
  1. reset
  2. rise (set)
  3. ack-clear of `vec`
  4. `if_wr` (load `if_wdata`)
  5. hold
- Consequences of that priority:
  - A set always wins over a clear or a write in the same cycle.
  - An ack-clear wins over a write of 1 to the same bit.
- Pending vector: `pend = if_q & ie`.
  - The winner is the lowest set index.
  - Bits >= N_SRC of `ie` and `if_wdata` are ignored.
- FSM states:
  - IDLE: `irq` = 0. If `pend != 0`, latch `vec` = winner and go to OFFER.
  - OFFER: `irq` = 1 and `vec` is frozen.
    - If `ack` = 1: clear `if_q[vec]` at this edge, drop `irq`, go to DONE.
    - Else if `pend[vec]` = 0 (flag cleared by a write, or enable dropped): drop `irq` and go to IDLE. No clear is performed.
  - DONE: `irq` = 0. Wait for `ack` = 0, then go to IDLE.
- A higher-priority flag arriving during OFFER does not preempt. It is serviced on the next IDLE pass.
- Reset, asynchronous and effective any time, including mid-handshake:
  - `if_q` = INITIAL_IF, `s`/`s_prev` = 0, `irq` = 0, `vec` = 0, state IDLE.
  - A source already high at reset release is not seen as a rise.

## Timing
- Without `IRQ_SYNC_EN`:
  - `src_req` high before posedge k gives `if_q` bit = 1 after edge k.
  - FSM enters OFFER and `irq` = 1 after edge k+1.
- With `IRQ_SYNC_EN`: both of the above occur two edges later (k+2 and k+3).
- `ack` sampled high at edge m: `if_q[vec]` = 0 and `irq` = 0 after edge m.
- Minimum time from `irq` drop to the next `irq`: 2 cycles (DONE with `ack` low, then IDLE).
- `if_wr` takes effect on `if_q` after the same edge it is sampled. The effect on `irq` follows one edge later.

## Configuration
- `IRQ_SYNC_EN` defined:
  - `src_req` passes through a 2-flop synchronizer before `s`.
  - Use this for sources in another clock domain.
  - Adds 2 cycles of latency.
- `IRQ_SYNC_EN` undefined: `src_req` is sampled directly into `s`.
- Handshake and flag priority are identical in both builds.

## Test plan
- Single source, no sync:
  - Stimulus: `ie`=5'b00100, pulse `src_req[2]` before edge 10.
  - Required: `if_q`=5'b00100 after edge 10; `irq`=1, `vec`=2 after edge 11.
  - Then `ack` high at edge 14: `if_q`=0, `irq`=0; state returns to IDLE once `ack` falls.
- Priority:
  - Stimulus: `ie`=5'b11111, set bits 1 and 3 together.
  - Required: `vec`=1 first; after its ack cycle, `irq` reasserts with `vec`=3.
- Simultaneous set and clear:
  - Stimulus: `if_wr` with `if_wdata`=0 in the same cycle as a rise on bit 0.
  - Required: `if_q[0]`=1.
  - Stimulus: rise on bit `vec` in the same cycle as `ack`.
  - Required: the flag stays 1 and the interrupt is re-offered.
- Withdrawal:
  - Stimulus: while in OFFER with `vec`=4, the CPU writes `if_wdata`=5'b00000.
  - Required: `irq`=0 next edge, no ack-clear, state IDLE.
- Reset mid-handshake:
  - Stimulus: `nreset` pulse between edges while in OFFER, with INITIAL_IF=5'b00001.
  - Required: `irq`=0 and `if_q`=5'b00001 immediately, without waiting for a clock edge.
  - Required: `irq`=1, `vec`=0 one edge after reset release, provided `ie[0]`=1.
- `IRQ_SYNC_EN` build:
  - Stimulus: repeat the single-source test.
  - Required: `if_q` set after edge 12 and `irq` after edge 13.
